// File: rtl/risc_v_multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath strobe and select as a Moore decode of the state
// (ALUControl, Bsel and ImmSrc additionally decode the IR fields).
// Build option: define CTRL_ILLEGAL_TRAP_EN to park in ILLEGAL until reset;
// otherwise an illegal encoding retires as a one-cycle NOP.
module risc_v_multicycle_controller #(
  parameter int STATE_W    = 4,
  parameter int FETCH_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] Bsel,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_EXE_R    = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_EXE_I    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JALR     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_LINK     = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_LUI      = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_ILLEGAL  = STATE_W'(14);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [1:0] WAIT_LAST = FETCH_WAIT[1:0];

  logic [STATE_W-1:0] state, state_nxt;
  logic [1:0]         wait_cnt;

  // Shifts (001/101) are not supported, every other func3 maps to an ALU op
  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 != 3'b001) && (f3 != 3'b101);
  endfunction

  // func3/func7 to ALUControl; func7 only selects sub for R-type 000
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  return sub_en ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b100;
      3'b100:  return 3'b101;
      3'b011:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // State register and FETCH wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 2'd1;
      else                                           wait_cnt <= 2'd0;
    end
  end

  // Next-state decode, including illegal-encoding detection in DECODE
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = (wait_cnt == WAIT_LAST) ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:    state_nxt = alu_f3_ok(func3) ? S_EXE_R : S_ILLEGAL;
          OP_I:    state_nxt = alu_f3_ok(func3) ? S_EXE_I : S_ILLEGAL;
          OP_LW,
          OP_SW:   state_nxt = (func3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
          OP_BR:   state_nxt = (func3[2:1] == 2'b00 || func3[2:1] == 2'b10) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:  state_nxt = S_JAL;
          OP_JALR: state_nxt = (func3 == 3'b000) ? S_JALR : S_ILLEGAL;
          OP_LUI:  state_nxt = S_LUI;
          default: state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXE_R,
      S_EXE_I,
      S_JAL,
      S_LINK:     state_nxt = S_ALUWB;
      S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_JALR:     state_nxt = S_LINK;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
`else
      S_ILLEGAL:  state_nxt = S_FETCH;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Moore output decode; everything is forced low while reset is asserted
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    Bsel       = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (wait_cnt == WAIT_LAST) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
      end
      S_EXE_R: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(func3, func7);
      end
      S_EXE_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(func3, 1'b0);
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        Branch     = 1'b1;
        instr_done = 1'b1;
        Bsel       = {func3[2], func3[0]};
      end
      S_JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_LUI: begin
        ImmSrc     = 3'b011;
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        instr_done = 1'b0;
`else
        instr_done = 1'b1;
`endif
      end
      default: ;
    endcase
    if (!rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      Bsel       = 2'b00;
      ALUControl = 3'b000;
      ImmSrc     = 3'b000;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// Directed bench for the multi-cycle controller. Outputs are packed into one
// 22-bit vector {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,Branch,instr_done,
// illegal,ResultSrc,ALUSrcA,ALUSrcB,Bsel,ALUControl,ImmSrc} and compared per
// cycle against hand-written expected vectors.
module tb_risc_v_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_w = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] func3 = 3'b000;
  logic func7 = 1'b0;

  logic pcw, adr, mw, irw, rw, br, dn, il;
  logic [1:0] rs, sa, sb, bs;
  logic [2:0] alu, imm;
  logic pcw2, adr2, mw2, irw2, rw2, br2, dn2, il2;
  logic [1:0] rs2, sa2, sb2, bs2;
  logic [2:0] alu2, imm2;

  logic [21:0] obs, obs2;
  assign obs  = {pcw, adr, mw, irw, rw, br, dn, il, rs, sa, sb, bs, alu, imm};
  assign obs2 = {pcw2, adr2, mw2, irw2, rw2, br2, dn2, il2, rs2, sa2, sb2, bs2, alu2, imm2};

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  risc_v_multicycle_controller #(.STATE_W(4), .FETCH_WAIT(0)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw), .RegWrite(rw),
    .Branch(br), .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb), .Bsel(bs),
    .ALUControl(alu), .ImmSrc(imm), .instr_done(dn), .illegal(il));

  risc_v_multicycle_controller #(.STATE_W(4), .FETCH_WAIT(2)) dut_w (
    .clk(clk), .rst(rst_w), .op(op), .func3(func3), .func7(func7),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2), .RegWrite(rw2),
    .Branch(br2), .ResultSrc(rs2), .ALUSrcA(sa2), .ALUSrcB(sb2), .Bsel(bs2),
    .ALUControl(alu2), .ImmSrc(imm2), .instr_done(dn2), .illegal(il2));

  localparam logic [21:0] V_ZERO     = 22'd0;
  localparam logic [21:0] V_FETCH    = {8'b1001_0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_FWAIT    = {8'b0000_0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_DEC_B    = {8'b0000_0000, 2'b00, 2'b01, 2'b01, 2'b00, 3'd0, 3'b010};
  localparam logic [21:0] V_DEC_J    = {8'b0000_0000, 2'b00, 2'b01, 2'b01, 2'b00, 3'd0, 3'b100};
  localparam logic [21:0] V_ALUWB    = {8'b0000_1010, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_MEMADR_L = {8'b0000_0000, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0, 3'b000};
  localparam logic [21:0] V_MEMADR_S = {8'b0000_0000, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0, 3'b001};
  localparam logic [21:0] V_MEMREAD  = {8'b0100_0000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_MEMWB    = {8'b0000_1010, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_MEMWRITE = {8'b0110_0010, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_JAL      = {8'b1000_0000, 2'b00, 2'b01, 2'b10, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_JALR     = {8'b1000_0000, 2'b10, 2'b10, 2'b01, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_LINK     = {8'b0000_0000, 2'b00, 2'b01, 2'b10, 2'b00, 3'd0, 3'd0};
  localparam logic [21:0] V_LUI      = {8'b0000_1010, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'b011};
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [21:0] V_ILL      = {8'b0000_0001, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
`else
  localparam logic [21:0] V_ILL      = {8'b0000_0011, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0};
`endif

  function automatic logic [21:0] v_exe_r(input logic [2:0] a);
    return {8'b0, 2'b00, 2'b10, 2'b00, 2'b00, a, 3'd0};
  endfunction
  function automatic logic [21:0] v_exe_i(input logic [2:0] a);
    return {8'b0, 2'b00, 2'b10, 2'b01, 2'b00, a, 3'd0};
  endfunction
  function automatic logic [21:0] v_branch(input logic [1:0] b);
    return {8'b0000_0110, 2'b00, 2'b10, 2'b00, b, 3'b001, 3'd0};
  endfunction

  // Hold reset over a clock edge with the given IR fields, release at a negedge,
  // then step 1 time unit so the first sample shows the FETCH cycle.
  task automatic start_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    rst = 1'b0;
    op = o; func3 = f3; func7 = f7;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rst_w = 1'b0;
    op = 7'b0110011; func3 = 3'b000; func7 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_ZERO) $display("FAIL reset_outputs got=%h exp=%h", obs, V_ZERO);
    else passes++;
    checks++;
    if (obs2 !== V_ZERO) $display("FAIL reset_outputs_w got=%h exp=%h", obs2, V_ZERO);
    else passes++;
  endtask

  task automatic test_add;
    logic [21:0] e[$];
    e = '{V_FETCH, V_DEC_B, v_exe_r(3'b000), V_ALUWB, V_FETCH};
    start_instr(7'b0110011, 3'b000, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL add cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
  endtask

  task automatic test_sub_lw_sw;
    logic [21:0] e[$];
    e = '{V_FETCH, V_DEC_B, v_exe_r(3'b001), V_ALUWB};
    start_instr(7'b0110011, 3'b000, 1'b1);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL sub cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
    e = '{V_FETCH, V_DEC_B, V_MEMADR_L, V_MEMREAD, V_MEMWB, V_FETCH};
    start_instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL lw cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
    e = '{V_FETCH, V_DEC_B, V_MEMADR_S, V_MEMWRITE, V_FETCH};
    start_instr(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL sw cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
  endtask

  task automatic test_branch;
    logic [2:0] f3s[4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic [1:0] bss[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [21:0] e[$];
    for (int k = 0; k < 4; k++) begin
      e = '{V_FETCH, V_DEC_B, v_branch(bss[k]), V_FETCH};
      start_instr(7'b1100011, f3s[k], 1'b0);
      for (int i = 0; i < e.size(); i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        checks++;
        if (obs !== e[i]) $display("FAIL branch_f3_%0d cyc%0d got=%h exp=%h", f3s[k], i, obs, e[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_jal_jalr_lui;
    logic [21:0] e[$];
    e = '{V_FETCH, V_DEC_J, V_JAL, V_ALUWB, V_FETCH};
    start_instr(7'b1101111, 3'b000, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL jal cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
    e = '{V_FETCH, V_DEC_B, V_JALR, V_LINK, V_ALUWB, V_FETCH};
    start_instr(7'b1100111, 3'b000, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL jalr cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
    e = '{V_FETCH, V_DEC_B, V_LUI, V_FETCH};
    start_instr(7'b0110111, 3'b101, 1'b1);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL lui cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
  endtask

  task automatic test_alu_map;
    logic [2:0] f3s[6] = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b100, 3'b011};
    logic [2:0] als[6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    for (int k = 0; k < 6; k++) begin
      start_instr(7'b0110011, f3s[k], 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (obs !== v_exe_r(als[k])) $display("FAIL exe_r_f3_%0d got=%h exp=%h", f3s[k], obs, v_exe_r(als[k]));
      else passes++;
      // func7 is ignored for I-type, so addi with func7=1 must still add
      start_instr(7'b0010011, f3s[k], 1'b1);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (obs !== v_exe_i(als[k])) $display("FAIL exe_i_f3_%0d got=%h exp=%h", f3s[k], obs, v_exe_i(als[k]));
      else passes++;
      @(negedge clk); #1;
      checks++;
      if (obs !== V_ALUWB) $display("FAIL exe_i_wb_f3_%0d got=%h exp=%h", f3s[k], obs, V_ALUWB);
      else passes++;
    end
  endtask

  task automatic test_illegal;
    logic [6:0] ops[8] = '{7'h7F, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1100011, 7'b1100111};
    logic [2:0] f3s[8] = '{3'b000, 3'b001, 3'b101, 3'b000, 3'b011, 3'b010, 3'b111, 3'b001};
    for (int k = 0; k < 8; k++) begin
      start_instr(ops[k], f3s[k], 1'b0);
      @(negedge clk); #1;
      checks++;
      if (obs !== V_DEC_B) $display("FAIL ill_dec_%0d got=%h exp=%h", k, obs, V_DEC_B);
      else passes++;
      @(negedge clk); #1;
      checks++;
      if (obs !== V_ILL) $display("FAIL ill_state_%0d got=%h exp=%h", k, obs, V_ILL);
      else passes++;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (k == 0) begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk); #1;
          checks++;
          if (obs !== V_ILL) $display("FAIL trap_hold cyc%0d got=%h exp=%h", c, obs, V_ILL);
          else passes++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== V_ZERO) $display("FAIL trap_reset got=%h exp=%h", obs, V_ZERO);
        else passes++;
      end
`else
      @(negedge clk); #1;
      checks++;
      if (obs !== V_FETCH) $display("FAIL ill_return_%0d got=%h exp=%h", k, obs, V_FETCH);
      else passes++;
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] e[$];
    e = '{V_FETCH, V_DEC_B, v_exe_r(3'b000), V_ALUWB,
          V_FETCH, V_DEC_B, V_MEMADR_L, V_MEMREAD, V_MEMWB, V_FETCH};
    start_instr(7'b0110011, 3'b000, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL b2b cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
      // Load the next instruction's IR fields while the add retires
      if (i == 3) begin op = 7'b0000011; func3 = 3'b010; end
    end
  endtask

  task automatic test_fetch_wait;
    logic [21:0] e[$];
    e = '{V_FWAIT, V_FWAIT, V_FETCH, V_DEC_B, v_exe_r(3'b000), V_ALUWB, V_FWAIT, V_FWAIT, V_FETCH};
    rst = 1'b0;
    rst_w = 1'b0;
    op = 7'b0110011; func3 = 3'b000; func7 = 1'b0;
    @(negedge clk);
    rst_w = 1'b1;
    #1;
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs2 !== e[i]) $display("FAIL fetch_wait cyc%0d got=%h exp=%h", i, obs2, e[i]);
      else passes++;
    end
    rst_w = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [21:0] e[$];
    e = '{V_FETCH, V_DEC_B, V_MEMADR_S, V_MEMWRITE};
    start_instr(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (obs !== e[i]) $display("FAIL abort_pre cyc%0d got=%h exp=%h", i, obs, e[i]);
      else passes++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== V_ZERO) $display("FAIL abort_now got=%h exp=%h", obs, V_ZERO);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if (obs !== V_ZERO) $display("FAIL abort_held got=%h exp=%h", obs, V_ZERO);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH) $display("FAIL abort_resume got=%h exp=%h", obs, V_FETCH);
    else passes++;
    @(negedge clk); #1;
    checks++;
    if (obs !== V_DEC_B) $display("FAIL abort_decode got=%h exp=%h", obs, V_DEC_B);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_lw_sw();
    test_branch();
    test_jal_jalr_lui();
    test_alu_map();
    test_illegal();
    test_back_to_back();
    test_fetch_wait();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
